// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: shifts stimulus patterns into a DFT scan chain, pulses capture, and
// compares each shifted-out response against its expected vector while the next pattern loads.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_stim,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic                 pat_last,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     pat_count,
  output logic [CNT_W-1:0]     fail_count
);

  localparam int unsigned IdxW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPat,
    StShift,
    StCapture,
    StFlush,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CHAIN_LEN-1:0]  stim_q, stim_d;
  logic [CHAIN_LEN-1:0]  exp_q, exp_d;
  logic                  last_q, last_d;
  logic [CHAIN_LEN-1:0]  cmp_q, cmp_d;
  logic                  pend_q, pend_d;
  logic                  err_q, err_d;
  logic                  scan_en_q, scan_en_d;
  logic                  scan_in_q, scan_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_W-1:0]      pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]      fail_cnt_q, fail_cnt_d;

  logic mismatch;
  logic err_now;
  logic shift_last;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stim_d     = stim_q;
    exp_d      = exp_q;
    last_d     = last_q;
    cmp_d      = cmp_q;
    pend_d     = pend_q;
    err_d      = err_q;
    scan_in_d  = scan_in_q;
    pat_cnt_d  = pat_cnt_q;
    fail_cnt_d = fail_cnt_q;

    // Response bit under test sits at the MSB of cmp_q; it shifts left with the chain.
    mismatch   = pend_q & (scan_out != cmp_q[CHAIN_LEN-1]);
    err_now    = err_q | mismatch;
    shift_last = (idx_q == LastIdx);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWaitPat;
          pat_cnt_d  = '0;
          fail_cnt_d = '0;
          pend_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      StWaitPat: begin
        if (pat_valid) begin
          state_d   = StShift;
          idx_d     = '0;
          scan_in_d = pat_stim[CHAIN_LEN-1];
          stim_d    = pat_stim << 1;
          exp_d     = pat_exp;
          last_d    = pat_last;
        end
      end

      StShift, StFlush: begin
        if (pend_q) begin
          err_d = err_now;
          cmp_d = cmp_q << 1;
        end
        if (shift_last) begin
          if (pend_q) begin
            if (pat_cnt_q != CntMax) pat_cnt_d = pat_cnt_q + CNT_W'(1);
            if (err_now && (fail_cnt_q != CntMax)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end
          if (state_q == StShift) begin
            state_d = StCapture;
          end else begin
            state_d = StDone;
            pend_d  = 1'b0;
          end
        end else begin
          idx_d     = idx_q + IdxW'(1);
          scan_in_d = (state_q == StShift) ? stim_q[CHAIN_LEN-1] : 1'b0;
          stim_d    = stim_q << 1;
        end
      end

      StCapture: begin
        cmp_d   = exp_q;
        pend_d  = 1'b1;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = last_q ? StFlush : StWaitPat;
      end

      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    scan_en_d = (state_d == StShift) || (state_d == StFlush);
    if (!scan_en_d || (state_d == StFlush)) scan_in_d = 1'b0;
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    done_d    = (state_d == StDone);
    pass_d    = done_d && (fail_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      stim_q     <= '0;
      exp_q      <= '0;
      last_q     <= 1'b0;
      cmp_q      <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pat_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stim_q     <= stim_d;
      exp_q      <= exp_d;
      last_q     <= last_d;
      cmp_q      <= cmp_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      pat_cnt_q  <= pat_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pat_ready  = (state_q == StWaitPat);
  assign scan_en    = scan_en_q;
  assign scan_in    = scan_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign pat_count  = pat_cnt_q;
  assign fail_count = fail_cnt_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl: two instances (8-bit and 2-bit counters) share stimulus,
// each driving its own 3-cell chain model that captures the inverted chain contents.
module tb_scan_test_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pat_valid = 1'b0;
  logic [2:0] pat_stim = '0;
  logic [2:0] pat_exp = '0;
  logic       pat_last = 1'b0;

  logic       pat_ready, scan_en, scan_in, scan_out, busy, done, pass;
  logic [7:0] pat_count, fail_count;
  logic       pat_ready2, scan_en2, scan_in2, scan_out2, busy2, done2, pass2;
  logic [1:0] pat_count2, fail_count2;

  logic [2:0] chain_q = '0;
  logic [2:0] chain2_q = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_test_ctrl #(.CHAIN_LEN(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_stim(pat_stim), .pat_exp(pat_exp), .pat_last(pat_last), .scan_en(scan_en),
    .scan_in(scan_in), .scan_out(scan_out), .busy(busy), .done(done), .pass(pass),
    .pat_count(pat_count), .fail_count(fail_count)
  );

  scan_test_ctrl #(.CHAIN_LEN(3), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready2),
    .pat_stim(pat_stim), .pat_exp(pat_exp), .pat_last(pat_last), .scan_en(scan_en2),
    .scan_in(scan_in2), .scan_out(scan_out2), .busy(busy2), .done(done2), .pass(pass2),
    .pat_count(pat_count2), .fail_count(fail_count2)
  );

  // Chain model: shift when scan_en, capture ~contents only in the capture cycle.
  always_ff @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[1:0], scan_in};
    else if (busy && !pat_ready) chain_q <= ~chain_q;
    if (scan_en2) chain2_q <= {chain2_q[1:0], scan_in2};
    else if (busy2 && !pat_ready2) chain2_q <= ~chain2_q;
  end
  assign scan_out  = chain_q[2];
  assign scan_out2 = chain2_q[2];

  typedef struct {
    logic [2:0] stim;
    logic [2:0] exp;
    logic       exp_pass;
    logic [7:0] exp_fail;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first shift cycle (i = 0).
  task automatic send_pat(input logic [2:0] s, input logic [2:0] e, input logic l);
    int n = 0;
    while (!pat_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pat_ready_wait", pat_ready, 1);
    pat_valid = 1'b1;
    pat_stim  = s;
    pat_exp   = e;
    pat_last  = l;
    @(negedge clk);
    pat_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    pulse_start();
    check("run_busy", busy, 1);
    check("run_ready", pat_ready, 1);
    check("run_done_clr", done, 0);
    send_pat(v.stim, v.exp, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k < 3) begin
        check("shift_en", scan_en, 1);
        check("shift_in", scan_in, v.stim[2-k]);
      end
      if (k == 3) check("capture_en", scan_en, 0);
      if (k == 6) check("done_early", done, 0);
      if (k == 7) check("done_latency", done, 1);
      if (k < 7) @(negedge clk);
    end
    check("run_pass", pass, v.exp_pass);
    check("run_pat_count", pat_count, 1);
    check("run_fail_count", fail_count, v.exp_fail);
    check("run_busy_end", busy, 0);
  endtask

  initial begin
    logic [2:0] snap;

    tbl[0] = '{stim: 3'b101, exp: 3'b010, exp_pass: 1'b1, exp_fail: 8'd0};
    tbl[1] = '{stim: 3'b101, exp: 3'b011, exp_pass: 1'b0, exp_fail: 8'd1};
    tbl[2] = '{stim: 3'b000, exp: 3'b111, exp_pass: 1'b1, exp_fail: 8'd0};
    tbl[3] = '{stim: 3'b111, exp: 3'b000, exp_pass: 1'b1, exp_fail: 8'd0};
    tbl[4] = '{stim: 3'b011, exp: 3'b100, exp_pass: 1'b1, exp_fail: 8'd0};
    tbl[5] = '{stim: 3'b011, exp: 3'b000, exp_pass: 1'b0, exp_fail: 8'd1};

    // Reset state
    #12;
    check("rst_scan_en", scan_en, 0);
    check("rst_scan_in", scan_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_ready", pat_ready, 0);
    check("rst_pat_count", pat_count, 0);
    check("rst_fail_count", fail_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    // Two patterns with a stall between them and a start pulse during SHIFT
    pulse_start();
    send_pat(3'b101, 3'b010, 1'b0);
    repeat (4) @(negedge clk);
    check("stall_ready", pat_ready, 1);
    snap = chain_q;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_ready", pat_ready, 1);
      check("stall_scan_en", scan_en, 0);
      check("stall_chain", chain_q, snap);
    end
    send_pat(3'b110, 3'b000, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ign_en", scan_en, 1);
    check("start_ign_ready", pat_ready, 0);
    check("start_ign_busy", busy, 1);
    wait_done();
    check("two_pat_count", pat_count, 2);
    check("two_fail_count", fail_count, 1);
    check("two_pass", pass, 0);

    // Restart from DONE, then saturation on the 2-bit instance
    pulse_start();
    check("restart_done", done, 0);
    check("restart_pass", pass, 0);
    check("restart_pat", pat_count, 0);
    check("restart_fail", fail_count, 0);
    check("restart_ready", pat_ready, 1);
    for (int p = 0; p < 5; p++) send_pat(3'b101, 3'b111, p == 4);
    wait_done();
    check("sat_main_pat", pat_count, 5);
    check("sat_main_fail", fail_count, 5);
    check("sat_pat", pat_count2, 3);
    check("sat_fail", fail_count2, 3);
    check("sat_done", done2, 1);
    check("sat_pass", pass2, 0);

    // Reset asserted mid-SHIFT (i = 1)
    pulse_start();
    send_pat(3'b101, 3'b010, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_scan_en", scan_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", pat_ready, 0);
    check("midrst_pat_count", pat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", pat_ready, 0);
    check("postrst_busy", busy, 0);
    run_vec(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
